// File: rtl/fifo_uart_tx_if.sv
// FIFO read-port bundle between the byte FIFO and its UART transmit consumer.
interface fifo_uart_tx_if #(
    parameter int unsigned DATA_WIDTH = 8
) ();
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_enb;

    modport master (output rd_enb, input fifo_empty, input rd_data);
    modport slave  (input rd_enb, output fifo_empty, output rd_data);
endinterface

// File: rtl/fifo_uart_tx.sv
// UART transmit back-end: pops bytes from the FIFO read port and serialises
// them as start / LSB-first data / optional parity / stop bit(s).
module fifo_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned PARITY_EN    = 0,
    parameter int unsigned PARITY_ODD   = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           tx_en,
    fifo_uart_tx_if.master fifo,
    output logic           tx,
    output logic           tx_busy,
    output logic           byte_done,
    output logic [15:0]    frame_count
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned BIT_W = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d, cnt_inc;
    logic [BIT_W-1:0]      bit_q, bit_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic                  par_q, par_d;
    logic                  tx_q, tx_d;
    logic                  rd_enb_q, rd_enb_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [15:0]           fc_q, fc_d;
    logic                  bit_end;

    // State and all registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            shreg_q  <= '0;
            par_q    <= 1'b0;
            tx_q     <= 1'b1;
            rd_enb_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            fc_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            shreg_q  <= shreg_d;
            par_q    <= par_d;
            tx_q     <= tx_d;
            rd_enb_q <= rd_enb_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            fc_q     <= fc_d;
        end
    end

    // Next-state and next-output logic; tx is set one edge ahead of each bit
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        shreg_d  = shreg_q;
        par_d    = par_q;
        tx_d     = tx_q;
        rd_enb_d = 1'b0;
        done_d   = 1'b0;
        fc_d     = fc_q;
        bit_end  = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));
        cnt_inc  = bit_end ? '0 : cnt_q + CNT_W'(1);

        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (tx_en && !fifo.fifo_empty) begin
                    rd_enb_d = 1'b1;
                    state_d  = FETCH;
                end
            end
            FETCH: state_d = LOAD;
            LOAD: begin
                shreg_d = fifo.rd_data;
                par_d   = (^fifo.rd_data) ^ (PARITY_ODD != 0);
                tx_d    = 1'b0;
                cnt_d   = '0;
                bit_d   = '0;
                state_d = START;
            end
            START: begin
                cnt_d = cnt_inc;
                if (bit_end) begin
                    tx_d    = shreg_q[0];
                    state_d = DATA;
                end
            end
            DATA: begin
                cnt_d = cnt_inc;
                if (bit_end) begin
                    if (bit_q == BIT_W'(DATA_WIDTH - 1)) begin
                        bit_d = '0;
                        if (PARITY_EN != 0) begin
                            tx_d    = par_q;
                            state_d = PARITY;
                        end else begin
                            tx_d    = 1'b1;
                            state_d = STOP;
                        end
                    end else begin
                        bit_d   = bit_q + BIT_W'(1);
                        shreg_d = shreg_q >> 1;
                        tx_d    = shreg_d[0];
                    end
                end
            end
            PARITY: begin
                cnt_d = cnt_inc;
                if (bit_end) begin
                    tx_d    = 1'b1;
                    state_d = STOP;
                end
            end
            STOP: begin
                cnt_d = cnt_inc;
                if (bit_end) begin
                    if (bit_q == BIT_W'(STOP_BITS - 1)) begin
                        bit_d   = '0;
                        done_d  = 1'b1;
                        fc_d    = fc_q + 16'd1;
                        state_d = IDLE;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    assign fifo.rd_enb = rd_enb_q;
    assign tx          = tx_q;
    assign tx_busy     = busy_q;
    assign byte_done   = done_q;
    assign frame_count = fc_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Scoreboard bench: three transmitter configurations fed from queue-modelled FIFOs,
// with line monitors decoding each frame against the expected byte.
module tb_fifo_uart_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]  rstn;
    logic [2:0]  en;
    logic        tx0, tx1, tx2, busy0, busy1, busy2, bd0, bd1, bd2;
    logic [15:0] fc0, fc1, fc2;
    logic [2:0]  tx_v, busy_v, bd_v, rde_v;

    fifo_uart_tx_if #(.DATA_WIDTH(8)) fif0 ();
    fifo_uart_tx_if #(.DATA_WIDTH(8)) fif1 ();
    fifo_uart_tx_if #(.DATA_WIDTH(8)) fif2 ();

    fifo_uart_tx #(.CLKS_PER_BIT(4)) dut0 (
        .clk(clk), .rst_n(rstn[0]), .tx_en(en[0]), .fifo(fif0),
        .tx(tx0), .tx_busy(busy0), .byte_done(bd0), .frame_count(fc0));

    fifo_uart_tx #(.CLKS_PER_BIT(3), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) dut1 (
        .clk(clk), .rst_n(rstn[1]), .tx_en(en[1]), .fifo(fif1),
        .tx(tx1), .tx_busy(busy1), .byte_done(bd1), .frame_count(fc1));

    fifo_uart_tx #(.CLKS_PER_BIT(2), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) dut2 (
        .clk(clk), .rst_n(rstn[2]), .tx_en(en[2]), .fifo(fif2),
        .tx(tx2), .tx_busy(busy2), .byte_done(bd2), .frame_count(fc2));

    assign tx_v   = {tx2, tx1, tx0};
    assign busy_v = {busy2, busy1, busy0};
    assign bd_v   = {bd2, bd1, bd0};
    assign rde_v  = {fif2.rd_enb, fif1.rd_enb, fif0.rd_enb};

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int n_rde[3]        = '{0, 0, 0};
    int last_rde_cyc[3] = '{0, 0, 0};
    int started[3]      = '{0, 0, 0};
    int start_cyc[3]    = '{0, 0, 0};
    int done_n[3]       = '{0, 0, 0};
    int exp_fc[3]       = '{0, 0, 0};
    int pushes[3]       = '{0, 0, 0};
    logic [2:0] prev_rde = 3'b000;
    logic gap_on = 1'b0;
    int   prev_start = -1;

    logic [7:0] q0[$], q1[$], q2[$];
    logic [7:0] e0[$], e1[$], e2[$];

    always @(posedge clk) cyc++;

    // Per-configuration constants taken straight from the instance parameters above
    function automatic int cpb(input int k);
        case (k)
            0: return 4;
            1: return 3;
            default: return 2;
        endcase
    endfunction
    function automatic int par_en(input int k);   return (k != 0) ? 1 : 0; endfunction
    function automatic logic par_odd(input int k); return (k == 2);        endfunction
    function automatic int stops(input int k);    return (k == 1) ? 2 : 1; endfunction
    function automatic logic line(input int k);   return tx_v[k];          endfunction

    function automatic logic [15:0] get_fc(input int k);
        case (k)
            0: return fc0;
            1: return fc1;
            default: return fc2;
        endcase
    endfunction

    function automatic int qsize(input int k);
        case (k)
            0: return q0.size();
            1: return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic int sb_size(input int k);
        case (k)
            0: return e0.size();
            1: return e1.size();
            default: return e2.size();
        endcase
    endfunction

    function automatic logic [7:0] sb_pop(input int k);
        case (k)
            0: return e0.pop_front();
            1: return e1.pop_front();
            default: return e2.pop_front();
        endcase
    endfunction

    task automatic upd_empty();
        fif0.fifo_empty = (q0.size() == 0);
        fif1.fifo_empty = (q1.size() == 0);
        fif2.fifo_empty = (q2.size() == 0);
    endtask

    task automatic push(input int k, input logic [7:0] b);
        case (k)
            0: begin q0.push_back(b); e0.push_back(b); end
            1: begin q1.push_back(b); e1.push_back(b); end
            default: begin q2.push_back(b); e2.push_back(b); end
        endcase
        pushes[k]++;
        upd_empty();
    endtask

    task automatic fifo_pop(input int k);
        case (k)
            0: fif0.rd_data = q0.pop_front();
            1: fif1.rd_data = q1.pop_front();
            default: fif2.rd_data = q2.pop_front();
        endcase
        upd_empty();
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // FIFO model plus rd_enb protocol: never on empty, never two cycles running
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rde_v[k] === 1'b1) begin
                n_rde[k]++;
                last_rde_cyc[k] = cyc;
                chk("rd_enb_protocol", {30'd0, prev_rde[k], qsize(k) == 0}, 32'd0);
                if (qsize(k) != 0) fifo_pop(k);
            end
            prev_rde[k] = (rde_v[k] === 1'b1);
        end
    end

    // Decode one frame that has just shown its start bit on line k
    task automatic frame_rx(input int k);
        int n, nb;
        logic [7:0]  b;
        logic [15:0] eb, rb;
        logic glitch, aborted;
        n  = cpb(k);
        nb = 9 + par_en(k) + stops(k);
        started[k]++;
        start_cyc[k] = cyc;
        chk("start_latency", cyc - last_rde_cyc[k], 32'd2);
        if (k == 0 && gap_on) begin
            if (prev_start >= 0) chk("frame_gap", cyc - prev_start, nb * n + 3);
            prev_start = cyc;
        end
        if (sb_size(k) == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_frame: got a start bit on line %0d, want no frame", k);
            b = 8'h00;
        end else begin
            b = sb_pop(k);
        end
        eb = '1;
        eb[0] = 1'b0;
        eb[8:1] = b;
        if (par_en(k) != 0) eb[9] = (^b) ^ par_odd(k);
        rb = '1;
        glitch = 1'b0;
        aborted = 1'b0;
        for (int c = 0; c < nb * n; c++) begin
            if (c != 0) @(negedge clk);
            if (rstn[k] !== 1'b1) begin
                aborted = 1'b1;
                break;
            end
            if (c % n == n / 2) rb[c / n] = line(k);
            if (line(k) !== eb[c / n] || busy_v[k] !== 1'b1 || bd_v[k] !== 1'b0) glitch = 1'b1;
        end
        if (!aborted) begin
            @(negedge clk);
            if (rstn[k] !== 1'b1) aborted = 1'b1;
        end
        if (!aborted) begin
            exp_fc[k] = (exp_fc[k] + 1) % 65536;
            chk("frame_data", {16'd0, rb}, {16'd0, eb});
            chk("frame_timing", {31'd0, glitch}, 32'd0);
            chk("end_status", {29'd0, bd_v[k], line(k), busy_v[k]}, 32'd6);
            chk("frame_count", {16'd0, get_fc(k)}, exp_fc[k]);
            done_n[k]++;
        end
    endtask

    task automatic monitor(input int k);
        forever begin
            @(negedge clk);
            if (rstn[k] === 1'b1 && line(k) === 1'b0) frame_rx(k);
        end
    endtask

    task automatic wait_frames(input int k, input int target, input int budget);
        int t = 0;
        while (done_n[k] < target && t < budget) begin
            @(negedge clk);
            t++;
        end
        chk("frames_done", done_n[k], target);
    endtask

    task automatic wait_start(input int k, input int s, input int budget);
        int t = 0;
        while (started[k] == s && t < budget) begin
            @(negedge clk);
            t++;
        end
        chk("frame_started", started[k], s + 1);
    endtask

    task automatic dut0_seq();
        int base, s, nb, target;
        base = n_rde[0];
        repeat (20) @(negedge clk);
        chk("idle_no_rd_enb", n_rde[0] - base, 32'd0);

        // Single byte 0xAA
        base = n_rde[0];
        push(0, 8'hAA);
        en[0] = 1'b1;
        wait_frames(0, 1, 200);
        chk("single_rd_enb", n_rde[0] - base, 32'd1);
        chk("single_count", {16'd0, fc0}, 32'd1);

        // Back-to-back drain of a full FIFO
        en[0] = 1'b0;
        for (int i = 0; i < 8; i++) push(0, 8'(8'h10 + i));
        prev_start = -1;
        gap_on = 1'b1;
        base = n_rde[0];
        en[0] = 1'b1;
        wait_frames(0, 9, 600);
        gap_on = 1'b0;
        chk("drain_rd_enb", n_rde[0] - base, 32'd8);
        chk("drain_empty", {31'd0, fif0.fifo_empty}, 32'd1);
        chk("drain_count", {16'd0, fc0}, 32'd9);

        // Drop tx_en during frame data: frame finishes, no further pops
        s = started[0];
        for (int i = 0; i < 3; i++) push(0, 8'($urandom));
        wait_start(0, s, 100);
        while (cyc < start_cyc[0] + 9) @(negedge clk);
        en[0] = 1'b0;
        wait_frames(0, 10, 100);
        base = n_rde[0];
        repeat (100) @(negedge clk);
        chk("gated_rd_enb", n_rde[0] - base, 32'd0);
        chk("gated_backlog", qsize(0), 32'd2);
        en[0] = 1'b1;
        wait_frames(0, 12, 300);

        // Random batches
        for (int r = 0; r < 3; r++) begin
            nb = int'($urandom_range(8, 1));
            target = done_n[0] + nb;
            for (int i = 0; i < nb; i++) push(0, 8'($urandom));
            wait_frames(0, target, nb * 50 + 100);
        end

        // Reset during data bit 3 of 0x5A; 0x3C must follow cleanly
        s = started[0];
        push(0, 8'h5A);
        push(0, 8'h3C);
        wait_start(0, s, 100);
        while (cyc < start_cyc[0] + 17) @(negedge clk);
        rstn[0] = 1'b0;
        exp_fc[0] = 0;
        target = done_n[0] + 1;
        @(negedge clk);
        chk("rst_mid_tx", {31'd0, tx0}, 32'd1);
        chk("rst_mid_busy", {31'd0, busy0}, 32'd0);
        chk("rst_mid_count", {16'd0, fc0}, 32'd0);
        chk("rst_mid_done", {31'd0, bd0}, 32'd0);
        @(negedge clk);
        rstn[0] = 1'b1;
        wait_frames(0, target, 200);
        chk("post_rst_count", {16'd0, fc0}, 32'd1);
        chk("post_rst_empty", qsize(0), 32'd0);
    endtask

    task automatic dut12_seq();
        int nb, t;
        en[1] = 1'b1;
        en[2] = 1'b1;
        push(1, 8'h07);
        push(2, 8'h07);
        for (int r = 0; r < 6; r++) begin
            t = 0;
            while ((qsize(1) != 0 || qsize(2) != 0) && t < 400) begin
                @(negedge clk);
                t++;
            end
            chk("parity_fifo_drained", qsize(1) + qsize(2), 32'd0);
            nb = int'($urandom_range(4, 1));
            for (int i = 0; i < nb; i++) begin
                push(1, 8'($urandom));
                push(2, 8'($urandom));
            end
        end
        wait_frames(1, pushes[1], 1000);
        wait_frames(2, pushes[2], 1000);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got no completion by %0t, want summary", $time);
        $fatal(1);
    end

    initial begin
        rstn = 3'b000;
        en   = 3'b000;
        fif0.rd_data = 8'h00;
        fif1.rd_data = 8'h00;
        fif2.rd_data = 8'h00;
        upd_empty();
        fork
            monitor(0);
            monitor(1);
            monitor(2);
        join_none
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_tx", {31'd0, tx0}, 32'd1);
        chk("reset_rd_enb", {31'd0, fif0.rd_enb}, 32'd0);
        chk("reset_busy", {31'd0, busy0}, 32'd0);
        chk("reset_count", {16'd0, fc0}, 32'd0);
        chk("reset_done", {31'd0, bd0}, 32'd0);
        rstn = 3'b111;
        fork
            dut0_seq();
            dut12_seq();
        join
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
